// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Holds the program counter, the instruction register (IR) and the operand
// word (imm) of the 16-bit CPU. It sits between the instruction ROM and the
// control-signal FSM. The IR is split into the fields the FSM and the
// operand loaders use.
//
// Strobe semantics: the control FSM drives single-cycle level strobes. There
// is no valid/ready handshake. A strobe acts on the rising clock edge that
// ends the cycle in which it is high, and only while en=1. A capture needs
// both ins_load and pc_load. ins_load alone is the FSM's default branch and
// does nothing.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset (overrides en)
//   en             fetch enable; 0 freezes all state
//   ins_load       capture request
//   pc_load        capture qualifier (capture = ins_load & pc_load)
//   pc_inc         advance pc by one (modulo 2^ADDR_W)
//   rom_addr       ROM address, combinationally equal to pc
//   rom_data       ROM word at rom_addr
//   pc             current program counter
//   opcode         IR[15:12]
//   op1_addr       IR[11:9]
//   op2_addr       IR[8:6]
//   imm            second word of a two-word instruction
//   imm_valid      imm belongs to the instruction currently in IR
//   byte2_pending  the next capture loads imm instead of IR
//   illegal        IR opcode is 1110 or 1111
//   pc_wrap        one-cycle pulse after pc wraps from all-ones to zero
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,  // the field map below assumes 16
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ins_load,
  input  logic              pc_load,
  input  logic              pc_inc,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        opcode,
  output logic [2:0]        op1_addr,
  output logic [2:0]        op2_addr,
  output logic [DATA_W-1:0] imm,
  output logic              imm_valid,
  output logic              byte2_pending,
  output logic              illegal,
  output logic              pc_wrap
);

  localparam logic [3:0] OP_MVI = 4'b1100;
  localparam logic [3:0] OP_LDA = 4'b1101;

  logic [DATA_W-1:0] ir;
  logic              do_capture;
  logic              do_inc;
  logic              two_word_op;
  logic              set_pending;

  // Qualified strobes. en gates everything, so the FSM's disabled pattern
  // (pc_inc=1, pc_load=1) cannot move the PC.
  assign do_capture = en & ins_load & pc_load;
  assign do_inc     = en & pc_inc;

  assign two_word_op = (ir[15:12] == OP_MVI) || (ir[15:12] == OP_LDA);

  // These inputs are register values, so they still show the pre-capture
  // IR/imm_valid when a capture and an increment share a cycle.
  // imm_valid=1 stops a second increment after the operand fetch from
  // re-arming the pending flag.
  assign set_pending = do_inc & ~byte2_pending & ~imm_valid & two_word_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= ADDR_W'(RESET_PC);
      ir            <= '0;
      imm           <= '0;
      imm_valid     <= 1'b0;
      byte2_pending <= 1'b0;
      pc_wrap       <= 1'b0;
    end else begin
      pc_wrap <= 1'b0;

      if (do_capture) begin
        if (byte2_pending) begin
          imm           <= rom_data;
          imm_valid     <= 1'b1;
          byte2_pending <= 1'b0;
        end else begin
          ir        <= rom_data;
          imm_valid <= 1'b0;
        end
      end

      // When set_pending is true, byte2_pending is 0. A capture in the
      // same cycle therefore only loads IR and never clears the flag, so
      // the two assignments to byte2_pending cannot conflict.
      if (set_pending) begin
        byte2_pending <= 1'b1;
      end

      if (do_inc) begin
        pc      <= pc + 1'b1;
        pc_wrap <= (pc == {ADDR_W{1'b1}});
      end
    end
  end

  // The capture uses the pre-increment pc because rom_addr is the register
  // value itself.
  assign rom_addr = pc;

  // Field decode straight from IR, with no added latency.
  assign opcode   = ir[15:12];
  assign op1_addr = ir[11:9];
  assign op2_addr = ir[8:6];
  assign illegal  = (ir[15:13] == 3'b111);

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic              clk;
  logic              rst;
  logic              en;
  logic              ins_load;
  logic              pc_load;
  logic              pc_inc;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [ADDR_W-1:0] pc;
  logic [3:0]        opcode;
  logic [2:0]        op1_addr;
  logic [2:0]        op2_addr;
  logic [DATA_W-1:0] imm;
  logic              imm_valid;
  logic              byte2_pending;
  logic              illegal;
  logic              pc_wrap;

  logic [DATA_W-1:0] rom [256];

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .ins_load     (ins_load),
    .pc_load      (pc_load),
    .pc_inc       (pc_inc),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .pc           (pc),
    .opcode       (opcode),
    .op1_addr     (op1_addr),
    .op2_addr     (op2_addr),
    .imm          (imm),
    .imm_valid    (imm_valid),
    .byte2_pending(byte2_pending),
    .illegal      (illegal),
    .pc_wrap      (pc_wrap)
  );

  // combinational ROM
  assign rom_data = rom[rom_addr];

  // ---------------------------------------------------------------- clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------- model
  // Instruction-level view: the program counter is an integer mod 256. The
  // model keeps the last instruction word, the operand word, and whether the
  // fetcher still owes the operand word of a two-word instruction.
  int          m_pc;
  logic [15:0] m_instr;
  logic [15:0] m_operand;
  bit          m_have_operand;
  bit          m_owe_operand;
  bit          m_wrapped;
  bit          checking = 0;

  function automatic bit needs_operand(input logic [15:0] w);
    int op;
    op = int'(w >> 12);
    return (op == 12) || (op == 13);   // MVI, LDA
  endfunction

  always @(posedge clk) begin
    int old_pc;
    bit owe_before;
    logic [15:0] instr_before;
    bit have_before;
    old_pc       = m_pc;
    owe_before   = m_owe_operand;
    instr_before = m_instr;
    have_before  = m_have_operand;
    if (rst) begin
      m_pc = 0; m_instr = 0; m_operand = 0;
      m_have_operand = 0; m_owe_operand = 0; m_wrapped = 0;
      checking = 1;
    end else begin
      m_wrapped = 0;
      if (en && ins_load && pc_load) begin
        if (owe_before) begin
          m_operand = rom[old_pc];
          m_have_operand = 1;
          m_owe_operand = 0;
        end else begin
          m_instr = rom[old_pc];
          m_have_operand = 0;
        end
      end
      if (en && pc_inc) begin
        m_pc = (old_pc + 1) % 256;
        m_wrapped = (m_pc < old_pc);
        if (!owe_before && !have_before && needs_operand(instr_before))
          m_owe_operand = 1;
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check("pc",            16'(pc),            16'(m_pc));
      check("rom_addr",      16'(rom_addr),      16'(m_pc));
      check("opcode",        16'(opcode),        16'(m_instr >> 12));
      check("op1_addr",      16'(op1_addr),      16'((m_instr >> 9) & 16'h7));
      check("op2_addr",      16'(op2_addr),      16'((m_instr >> 6) & 16'h7));
      check("imm",           imm,                m_operand);
      check("imm_valid",     16'(imm_valid),     16'(m_have_operand));
      check("byte2_pending", 16'(byte2_pending), 16'(m_owe_operand));
      check("illegal",       16'(illegal),       16'((m_instr >> 12) >= 14));
      check("pc_wrap",       16'(pc_wrap),       16'(m_wrapped));
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic step(input logic r, input logic e, input logic il,
                      input logic pl, input logic pi);
    rst = r; en = e; ins_load = il; pc_load = pl; pc_inc = pi;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();   step(1, 1, 0, 0, 0); endtask
  task automatic capture();    step(0, 1, 1, 1, 0); endtask
  task automatic inc();        step(0, 1, 0, 0, 1); endtask
  task automatic cap_inc();    step(0, 1, 1, 1, 1); endtask
  task automatic idle();       step(0, 1, 0, 0, 0); endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst = 0; en = 0; ins_load = 0; pc_load = 0; pc_inc = 0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h2000 | 16'(i);
    rom[0] = 16'h0A40;   // ADD op1=5 op2=1
    rom[1] = 16'hC600;   // MVI
    rom[2] = 16'h1234;
    rom[3] = 16'hD000;   // LDA
    rom[4] = 16'hE000;   // illegal
    rom[5] = 16'hD123;   // LDA, fetched with capture+inc together
    rom[6] = 16'h0000;
    rom[7] = 16'hBEEF;   // its operand word
    @(negedge clk);

    // reset state
    do_reset();
    check("rst pc", 16'(pc), 16'h0000);
    check("rst opcode", 16'(opcode), 16'h0000);
    check("rst pending", 16'(byte2_pending), 16'h0000);

    // one-word fetch
    capture(); inc();
    check("add opcode", 16'(opcode), 16'h0000);
    check("add op1", 16'(op1_addr), 16'h0005);
    check("add op2", 16'(op2_addr), 16'h0001);
    check("add pc", 16'(pc), 16'h0001);

    // MVI two-word
    capture(); inc();
    check("mvi pending", 16'(byte2_pending), 16'h0001);
    capture(); inc();
    check("mvi opcode", 16'(opcode), 16'h000C);
    check("mvi imm", imm, 16'h1234);
    check("mvi imm_valid", 16'(imm_valid), 16'h0001);
    check("mvi pending clr", 16'(byte2_pending), 16'h0000);
    check("mvi pc", 16'(pc), 16'h0003);

    // reset mid-LDA
    capture(); inc();
    check("lda pending", 16'(byte2_pending), 16'h0001);
    do_reset();
    check("lda rst pending", 16'(byte2_pending), 16'h0000);
    check("lda rst pc", 16'(pc), 16'h0000);
    capture();
    check("post rst ir", 16'(op1_addr), 16'h0005);
    check("post rst imm_valid", 16'(imm_valid), 16'h0000);

    // ins_load without pc_load, then real capture of illegal word
    for (int i = 0; i < 4; i++) inc();
    step(0, 1, 1, 0, 0);
    check("no-qual opcode", 16'(opcode), 16'h0000);
    capture();
    check("illegal set", 16'(illegal), 16'h0001);
    inc();
    check("illegal no pending", 16'(byte2_pending), 16'h0000);
    check("illegal pc", 16'(pc), 16'h0005);

    // en=0 freeze with the disabled strobe pattern
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 1);
    check("frozen pc", 16'(pc), 16'h0005);
    check("frozen opcode", 16'(opcode), 16'h000E);

    // capture+inc together: pending decision uses the pre-capture IR (E000)
    cap_inc();
    check("ci opcode", 16'(opcode), 16'h000D);
    check("ci no pending", 16'(byte2_pending), 16'h0000);
    inc();
    check("ci pending", 16'(byte2_pending), 16'h0001);
    cap_inc();
    check("ci imm", imm, 16'hBEEF);
    check("ci pending clr", 16'(byte2_pending), 16'h0000);
    check("ci pc", 16'(pc), 16'h0008);
    inc();   // imm_valid guard: must not re-arm
    check("ci guard", 16'(byte2_pending), 16'h0000);

    // wrap: pc is 9 here, step to 255
    while (pc != 8'hFF && n_checks < 100000) inc();
    check("pre-wrap pc", 16'(pc), 16'h00FF);
    inc();
    check("wrap pc", 16'(pc), 16'h0000);
    check("wrap pulse", 16'(pc_wrap), 16'h0001);
    idle();
    check("wrap pulse end", 16'(pc_wrap), 16'h0000);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
